// File: rtl/comparador_serial_ctrl.sv
// Sequential MSB-first magnitude comparator: one bit per clock, result reported on a DONE pulse.
// Optional build macro COMPARADOR_EARLY_EXIT_EN ends the scan right after the first mismatch.
module comparador_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_l,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_z,
    output logic             o_gt,
    output logic             o_eq
);

    localparam int unsigned IdxW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StScan, StFin} state_e;

    state_e            r_state, w_state;
    logic [WIDTH-1:0]  r_a, w_a;
    logic [WIDTH-1:0]  r_b, w_b;
    logic [IdxW-1:0]   r_idx, w_idx;
    logic              r_gt, w_gt;
    logic              r_decided, w_decided;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_z, w_z;
    logic              r_gt_o, w_gt_o;
    logic              r_eq, w_eq;
    logic              w_mismatch;
    logic              w_first_mismatch;
    logic              w_last;
    logic              w_exit;

    always_ff @(posedge i_clk) begin
        if (!i_reset_l) begin
            r_state   <= StIdle;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_gt      <= 1'b0;
            r_decided <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_z       <= 1'b0;
            r_gt_o    <= 1'b0;
            r_eq      <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_a       <= w_a;
            r_b       <= w_b;
            r_idx     <= w_idx;
            r_gt      <= w_gt;
            r_decided <= w_decided;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_z       <= w_z;
            r_gt_o    <= w_gt_o;
            r_eq      <= w_eq;
        end
    end

    always_comb begin
        w_state          = r_state;
        w_a              = r_a;
        w_b              = r_b;
        w_idx            = r_idx;
        w_gt             = r_gt;
        w_decided        = r_decided;
        w_busy           = r_busy;
        w_done           = 1'b0;
        w_z              = r_z;
        w_gt_o           = r_gt_o;
        w_eq             = r_eq;
        w_mismatch       = r_a[r_idx] ^ r_b[r_idx];
        w_first_mismatch = w_mismatch & ~r_decided;
        w_last           = (r_idx == '0);
        w_exit           = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_busy = 1'b0;
                if (i_start) begin
                    w_a       = i_a;
                    w_b       = i_b;
                    w_idx     = IdxW'(WIDTH - 1);
                    w_decided = 1'b0;
                    w_gt      = 1'b0;
                    w_busy    = 1'b1;
                    w_state   = StScan;
                end
            end
            StScan: begin
                // Only the most significant mismatch decides the ordering.
                if (w_first_mismatch) begin
                    w_gt      = r_a[r_idx];
                    w_decided = 1'b1;
                end
`ifdef COMPARADOR_EARLY_EXIT_EN
                w_exit = w_last | w_first_mismatch;
`else
                w_exit = w_last;
`endif
                if (!w_last) begin
                    w_idx = r_idx - IdxW'(1);
                end
                // Results land on the same edge that enters FIN, so use next-state values.
                if (w_exit) begin
                    w_state = StFin;
                    w_done  = 1'b1;
                    w_gt_o  = w_gt;
                    w_z     = ~w_gt;
                    w_eq    = ~w_decided;
                end
            end
            StFin: begin
                w_busy  = 1'b0;
                w_state = StIdle;
            end
            default: begin
                w_busy  = 1'b0;
                w_state = StIdle;
            end
        endcase
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_z    = r_z;
    assign o_gt   = r_gt_o;
    assign o_eq   = r_eq;

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Self-checking bench for comparador_serial_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_comparador_serial_ctrl;

    localparam int unsigned W       = 8;
    localparam int          TIMEOUT = 40;

    logic         clk;
    logic         rst_l;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         z;
    logic         gt;
    logic         eq;

    int           total;
    int           bad;
    logic [2:0]   prev_exp;

    comparador_serial_ctrl #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_reset_l (rst_l),
        .i_start   (start),
        .i_a       (a),
        .i_b       (b),
        .o_busy    (busy),
        .o_done    (done),
        .o_z       (z),
        .o_gt      (gt),
        .o_eq      (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Z, GT, EQ}
    function automatic logic [2:0] exp_res(input logic [W-1:0] x, input logic [W-1:0] y);
        return {x <= y, x > y, x == y};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef COMPARADOR_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i] != y[i]) return W - i + 1;
        end
`endif
        return W + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in the current cycle and reports what was observed.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit poke,
                          output int lat, output logic [2:0] res, output logic [2:0] res_acc,
                          output bit busy_ok, output bit one_pulse);
        int cnt;
        busy_ok   = 1'b1;
        one_pulse = 1'b1;
        lat       = -1;
        res       = 3'bxxx;
        a         = xa;
        b         = xb;
        start     = 1'b1;
        step();
        start = poke;
        if (poke) begin
            a = '1;
            b = '0;
        end
        res_acc = {z, gt, eq};
        cnt = 1;
        while (!done && cnt < TIMEOUT) begin
            if (!busy) busy_ok = 1'b0;
            step();
            cnt++;
        end
        if (done) begin
            lat = cnt;
            if (!busy) busy_ok = 1'b0;
            res = {z, gt, eq};
        end
        start = 1'b0;
        step();
        if (done) one_pulse = 1'b0;
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h22;
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++;
        if ({z, gt, eq} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {z, gt, eq});
        end
        start = 1'b0;
        rst_l = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
        prev_exp = 3'b000;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input bit poke);
        int         lat;
        logic [2:0] res, res_acc, want;
        bit         busy_ok, one_pulse;
        want = exp_res(xa, xb);
        run_op(xa, xb, poke, lat, res, res_acc, busy_ok, one_pulse);
        total++;
        if (res !== want) begin
            bad++; $display("FAIL %s_flags a=%h b=%h got=%b want=%b", name, xa, xb, res, want);
        end
        total++;
        if (lat != exp_lat(xa, xb)) begin
            bad++; $display("FAIL %s_latency a=%h b=%h got=%0d want=%0d", name, xa, xb, lat,
                            exp_lat(xa, xb));
        end
        total++;
        if (res_acc !== prev_exp) begin
            bad++; $display("FAIL %s_hold got=%b want=%b", name, res_acc, prev_exp);
        end
        total++;
        if (!busy_ok) begin bad++; $display("FAIL %s_busy got=bad_window want=ok", name); end
        total++;
        if (!one_pulse) begin bad++; $display("FAIL %s_done_width got=2+ want=1", name); end
        prev_exp = want;
    endtask

    task automatic test_equal();
        check_op("equal", 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_msb_mismatch();
        check_op("msb", 8'h80, 8'h7F, 1'b0);
    endtask

    task automatic test_lsb_mismatch();
        check_op("lsb", 8'h00, 8'h01, 1'b0);
    endtask

    task automatic test_back_to_back();
        check_op("bit6", 8'hE7, 8'h81, 1'b0);
        check_op("b2b", 8'h0A, 8'h09, 1'b0);
    endtask

    task automatic test_busy_protect();
        check_op("busyprot", 8'h10, 8'h20, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = (n % 5 == 0) ? ra : W'($urandom);
            if (n % 7 == 3) rb = ra ^ W'(1 << $urandom_range(W - 1, 0));
            check_op("random", ra, rb, 1'b0);
        end
    endtask

    task automatic test_reset_midscan();
        int seen;
        a     = 8'h01;
        b     = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++;
        if ({z, gt, eq} !== 3'b000) begin
            bad++; $display("FAIL abort_flags got=%b want=000", {z, gt, eq});
        end
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            if (done) seen++;
            step();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_done got=%0d want=0", seen); end
        prev_exp = 3'b000;
        check_op("recover", 8'h33, 8'h34, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_l = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_equal();
        test_msb_mismatch();
        test_lsb_mismatch();
        test_back_to_back();
        test_busy_protect();
        test_random();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
